cordic_gain_comp: RTL and testbench

- Downstream stage of the iterative 18-bit CORDIC rotator. It captures each result (x, y, z) on the rotator's done pulse.
- It removes the CORDIC gain from x and y by multiplying each by KINV ≈ 1/1.64676, using a sequential shift-add multiplier. z passes through unchanged.
- Results are presented on a valid/ready output interface.
- A one-entry pending buffer absorbs a result that arrives while the block is busy. An overrun flag reports any result lost beyond that.

---
 rtl/cordic_gain_comp.sv | 207 ++++++++++++++++++++
 tb/tb_cordic_gain_comp.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_gain_comp.sv
// Gain compensation after the iterative CORDIC rotator: x and y are scaled by
// 1/K with a bit-serial shift-add multiplier, z passes through, valid/ready out.
module cordic_gain_comp #(
  parameter int          W    = 18,
  parameter int unsigned KINV = 32'd79594
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_done,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic [W-1:0] in_z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y,
  output logic [W-1:0] out_z,
  output logic         busy,
  output logic         overrun,
  input  logic         clr_ovr
);

  localparam int AW = 2 * W - 1;
  localparam logic [16:0] KINV_BITS = KINV[16:0];
  localparam logic signed [AW-1:0] HALF_LSB = AW'(32'sd65536);

  typedef enum logic [1:0] {IDLE, MUL, ROUND, OUT} state_t;

  state_t                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic signed [W-1:0]    x_q, x_d, y_q, y_d;
  logic [W-1:0]           z_q, z_d;
  logic signed [AW-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic                   pend_full_q, pend_full_d;
  logic [W-1:0]           pend_x_q, pend_x_d, pend_y_q, pend_y_d, pend_z_q, pend_z_d;
  logic                   out_valid_q, out_valid_d;
  logic [W-1:0]           out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;

  logic                   hs_s, drain_s, direct_s, take_s, ovr_set_s, start_s;
  logic [W-1:0]           ld_x_s, ld_y_s, ld_z_s;
  logic signed [AW-1:0]   x_ext_s, y_ext_s;

  // Next-state logic: sequencing, serial multiply, rounding and pending buffer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    pend_full_d = pend_full_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_z_d    = pend_z_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_z_d     = out_z_q;
    overrun_d   = overrun_q;
    ovr_set_s   = 1'b0;
    start_s     = 1'b0;
    ld_x_s      = in_x;
    ld_y_s      = in_y;
    ld_z_s      = in_z;
    x_ext_s     = {{(AW-W){x_q[W-1]}}, x_q};
    y_ext_s     = {{(AW-W){y_q[W-1]}}, y_q};

    hs_s     = out_valid_q & out_ready;
    drain_s  = (state_q == OUT) & hs_s & pend_full_q;
    direct_s = (state_q == OUT) & hs_s & ~pend_full_q & in_done;
    take_s   = (state_q == IDLE) & in_done;

    case (state_q)
      IDLE: begin
        if (in_done) start_s = 1'b1;
        else         start_s = 1'b0;
      end
      MUL: begin
        if (KINV_BITS[cnt_q]) begin
          acc_x_d = acc_x_q + (x_ext_s << cnt_q);
          acc_y_d = acc_y_q + (y_ext_s << cnt_q);
        end else begin
          acc_x_d = acc_x_q;
          acc_y_d = acc_y_q;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd16) state_d = ROUND;
        else                state_d = MUL;
      end
      ROUND: begin
        // Round half up, then drop the 17 fraction bits of KINV.
        out_x_d     = W'((acc_x_q + HALF_LSB) >>> 17);
        out_y_d     = W'((acc_y_q + HALF_LSB) >>> 17);
        out_z_d     = z_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (hs_s) begin
          out_valid_d = 1'b0;
          if (pend_full_q) begin
            start_s = 1'b1;
            ld_x_s  = pend_x_q;
            ld_y_s  = pend_y_q;
            ld_z_s  = pend_z_q;
          end else if (in_done) begin
            start_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_s) begin
      state_d = MUL;
      cnt_d   = 5'd0;
      acc_x_d = '0;
      acc_y_d = '0;
      x_d     = ld_x_s;
      y_d     = ld_y_s;
      z_d     = ld_z_s;
    end else begin
      x_d = x_q;
      y_d = y_q;
      z_d = z_q;
    end

    // A result the engine cannot take goes to pending; pending refills on a same-cycle drain.
    if (in_done && !take_s && !direct_s) begin
      if (!pend_full_q || drain_s) begin
        pend_full_d = 1'b1;
        pend_x_d    = in_x;
        pend_y_d    = in_y;
        pend_z_d    = in_z;
      end else begin
        ovr_set_s   = 1'b1;
        pend_full_d = 1'b1;
      end
    end else if (drain_s) begin
      pend_full_d = 1'b0;
    end else begin
      pend_full_d = pend_full_q;
    end

    if (ovr_set_s)    overrun_d = 1'b1;
    else if (clr_ovr) overrun_d = 1'b0;
    else              overrun_d = overrun_q;

    busy_d = (state_d != IDLE) | pend_full_d;
  end

  // State and data registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      pend_full_q <= 1'b0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_z_q    <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_z_q     <= '0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      pend_full_q <= pend_full_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pend_z_q    <= pend_z_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_z_q     <= out_z_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_z     = out_z_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Scoreboard bench for cordic_gain_comp: directed vectors push expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_cordic_gain_comp;
  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_done = 1'b0;
  logic [W-1:0] in_x = '0, in_y = '0, in_z = '0;
  logic         out_valid, busy, overrun;
  logic         out_ready = 1'b1;
  logic         clr_ovr = 1'b0;
  logic [W-1:0] out_x, out_y, out_z;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {int x; int y; int z;} exp_t;
  exp_t exp_q[$];

  typedef struct {int x; int y; int z; int ex; int ey; int ez;} vec_t;
  vec_t vecs[4];

  cordic_gain_comp #(.W(W), .KINV(32'd79594)) dut (
    .clk(clk), .rst(rst), .in_done(in_done), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .busy(busy), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int x, input int y, input int z, input bit push,
                       input int ex, input int ey, input int ez);
    exp_t e;
    in_x = W'(x);
    in_y = W'(y);
    in_z = W'(z);
    in_done = 1'b1;
    if (push) begin
      e.x = ex; e.y = ey; e.z = ez;
      exp_q.push_back(e);
    end
    tick();
    in_done = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    check({name, "_valid"}, int'(out_valid), 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || out_valid) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_idle"}, int'(busy | out_valid), 0);
  endtask

  // Monitor: compares each accepted word and the stability of any stalled word.
  initial begin
    exp_t e;
    bit held = 1'b0;
    int hx = 0, hy = 0, hz = 0;
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        if (held) begin
          check("hold_x", int'($signed(out_x)), hx);
          check("hold_y", int'($signed(out_y)), hy);
          check("hold_z", int'($signed(out_z)), hz);
        end
        if (out_ready) begin
          held = 1'b0;
          check("sb_has_entry", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_x", int'($signed(out_x)), e.x);
            check("out_y", int'($signed(out_y)), e.y);
            check("out_z", int'($signed(out_z)), e.z);
          end
        end else begin
          held = 1'b1;
          hx = int'($signed(out_x));
          hy = int'($signed(out_y));
          hz = int'($signed(out_z));
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, t1;
    vecs[0] = '{131071, -131072,     -7,  79593, -79594,     -7};
    vecs[1] = '{     0,       0,      0,      0,      0,      0};
    vecs[2] = '{     1,      -1,      5,      1,     -1,      5};
    vecs[3] = '{  1000,      -3, 131071,    607,     -2, 131071};

    #1 rst = 1'b0;
    tick();
    tick();
    check("rst_valid", int'(out_valid), 0);
    check("rst_x", int'(out_x), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovr", int'(overrun), 0);
    rst = 1'b1;
    tick();

    // Basic multiply with latency measurement.
    pulse(100000, -100000, 12345, 1'b1, 60725, -60725, 12345);
    check("busy_run", int'(busy), 1);
    wait_valid("basic", n);
    check("latency", n, 18);
    wait_idle("basic");

    for (int i = 0; i < 4; i++) begin
      pulse(vecs[i].x, vecs[i].y, vecs[i].z, 1'b1, vecs[i].ex, vecs[i].ey, vecs[i].ez);
      wait_valid("vec", n);
      check("vec_latency", n, 18);
      wait_idle("vec");
    end

    // Backpressure: word must stay put for 30 cycles, then exactly one handshake.
    out_ready = 1'b0;
    pulse(2000, 50000, -42, 1'b1, 1215, 30363, -42);
    wait_valid("bp", n);
    repeat (30) tick();
    check("bp_still_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    check("bp_dropped_valid", int'(out_valid), 0);
    wait_idle("bp");

    // Pending buffer then overrun on the third result.
    pulse(100000, 0, 1, 1'b1, 60725, 0, 1);
    repeat (5) tick();
    pulse(-100000, 1000, 2, 1'b1, -60725, 607, 2);
    check("pend_no_ovr", int'(overrun), 0);
    check("pend_busy", int'(busy), 1);
    repeat (5) tick();
    pulse(7, 7, 3, 1'b0, 0, 0, 0);
    check("ovr_set", int'(overrun), 1);
    wait_idle("pend");
    check("ovr_sticky", int'(overrun), 1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_clr", int'(overrun), 0);

    // Clear coincident with a drop: the set must win.
    pulse(1, 1, 4, 1'b1, 1, 1, 4);
    repeat (5) tick();
    pulse(-1, -1, 5, 1'b1, -1, -1, 5);
    repeat (5) tick();
    clr_ovr = 1'b1;
    pulse(9, 9, 6, 1'b0, 0, 0, 0);
    clr_ovr = 1'b0;
    check("ovr_set_wins", int'(overrun), 1);
    wait_idle("clrdrop");
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;

    // Handshake and in_done in the same cycle: back-to-back, 19 cycles apart.
    pulse(131071, 1, 7, 1'b1, 79593, 1, 7);
    wait_valid("b2b_first", n);
    t1 = cyc;
    pulse(-131072, 100000, 8, 1'b1, -79594, 60725, 8);
    wait_valid("b2b_second", n);
    check("b2b_gap", cyc - t1, 19);
    wait_idle("b2b");

    // Reset in the middle of MUL, then a clean result.
    pulse(100000, -100000, 9, 1'b1, 0, 0, 0);
    repeat (8) tick();
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("mrst_x", int'(out_x), 0);
    check("mrst_y", int'(out_y), 0);
    check("mrst_z", int'(out_z), 0);
    check("mrst_valid", int'(out_valid), 0);
    check("mrst_busy", int'(busy), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    pulse(2000, 50000, -42, 1'b1, 1215, 30363, -42);
    wait_valid("post_rst", n);
    check("post_rst_latency", n, 18);
    wait_idle("post_rst");

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
